ysyx_rob: RTL

Parametrised reorder buffer with integrated register-rename status for the out-of-order backend. It sits between dispatch and the WBU/CSR/LSU commit stage. It accepts in-order allocations, absorbs results from `WB_PORTS` execute ports, and resolves source operands against in-flight entries. It retires up to `COMMIT_WIDTH` completed entries per cycle in program order, stopping at serialising or redirecting entries.

---
 rtl/ysyx_rob.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_rob.sv
// ysyx_rob: reorder buffer with rename status, in-order commit of up to two entries.
// Optional YSYX_ROB_BYPASS_EN: source lookup also matches same-cycle writebacks.
module ysyx_rob #(
  parameter  int DEPTH        = 16,
  parameter  int WB_PORTS     = 2,
  parameter  int COMMIT_WIDTH = 2,
  parameter  int XLEN         = 32,
  localparam int IDX_W        = $clog2(DEPTH),
  localparam int TAG_W        = IDX_W + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [4:0]                disp_rd,
  input  logic [XLEN-1:0]           disp_pc,
  input  logic [XLEN-1:0]           disp_pnpc,
  input  logic                      disp_store,
  input  logic                      disp_serial,
  output logic [TAG_W-1:0]          disp_tag,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  output logic                      src1_ready,
  output logic                      src2_ready,
  output logic [XLEN-1:0]           src1_value,
  output logic [XLEN-1:0]           src2_value,
  output logic [TAG_W-1:0]          src1_tag,
  output logic [TAG_W-1:0]          src2_tag,
  input  logic [WB_PORTS-1:0]       wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
  input  logic [WB_PORTS*XLEN-1:0]  wb_value,
  input  logic [WB_PORTS*XLEN-1:0]  wb_npc,
  input  logic [WB_PORTS-1:0]       wb_trap,
  input  logic                      sq_ready,
  output logic [COMMIT_WIDTH-1:0]      cm_valid,
  output logic [COMMIT_WIDTH*5-1:0]    cm_rd,
  output logic [COMMIT_WIDTH*XLEN-1:0] cm_value,
  output logic [COMMIT_WIDTH*XLEN-1:0] cm_pc,
  output logic [COMMIT_WIDTH*XLEN-1:0] cm_npc,
  output logic [COMMIT_WIDTH-1:0]      cm_store,
  output logic                      cm_redirect,
  output logic [TAG_W-1:0]          count
);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_EX   = 2'd1,
    ST_WB   = 2'd2
  } st_e;

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [TAG_W-1:0] count_q, count_d;
  logic             redir_q, redir_d;
  logic [31:0]      busy_q, busy_d;
  logic [IDX_W-1:0] rmt_q [32];
  logic [IDX_W-1:0] rmt_d [32];

  st_e              st_q     [DEPTH];
  st_e              st_d     [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [4:0]       rd_d     [DEPTH];
  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [XLEN-1:0]  pc_d     [DEPTH];
  logic [XLEN-1:0]  pnpc_q   [DEPTH];
  logic [XLEN-1:0]  pnpc_d   [DEPTH];
  logic [XLEN-1:0]  val_q    [DEPTH];
  logic [XLEN-1:0]  val_d    [DEPTH];
  logic [XLEN-1:0]  npc_q    [DEPTH];
  logic [XLEN-1:0]  npc_d    [DEPTH];
  logic             store_q  [DEPTH];
  logic             store_d  [DEPTH];
  logic             serial_q [DEPTH];
  logic             serial_d [DEPTH];
  logic             trap_q   [DEPTH];
  logic             trap_d   [DEPTH];

  logic             fire;
  logic [TAG_W-1:0] ncm;
  logic [IDX_W-1:0] cidx [COMMIT_WIDTH];

  assign count      = count_q;
  assign disp_ready = (count_q < TAG_W'(DEPTH)) && !redir_q;
  assign disp_tag   = TAG_W'({1'b0, tail_q}) + TAG_W'(1);
  assign fire       = disp_valid && disp_ready;

  for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_cidx
    assign cidx[k] = head_q + IDX_W'(k);
  end

  // Commit group: stops at the first non-ready slot or after a redirect/serial.
  logic cm_blk;
  logic cm_sseen;
  logic cm_ok;
  logic cm_rdr;

  always_comb begin
    cm_valid    = '0;
    cm_rd       = '0;
    cm_value    = '0;
    cm_pc       = '0;
    cm_npc      = '0;
    cm_store    = '0;
    cm_redirect = 1'b0;
    ncm         = '0;
    cm_blk      = redir_q;
    cm_sseen    = 1'b0;
    cm_ok       = 1'b0;
    cm_rdr      = 1'b0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      cm_ok = !cm_blk && (TAG_W'(k) < count_q)
              && (st_q[cidx[k]] == ST_WB);
      if (store_q[cidx[k]] && (!sq_ready || cm_sseen))
        cm_ok = 1'b0;
      if (serial_q[cidx[k]] && k != 0)
        cm_ok = 1'b0;
      cm_rdr = trap_q[cidx[k]]
               || (npc_q[cidx[k]] != pnpc_q[cidx[k]]);
      if (cm_ok) begin
        cm_valid[k]            = 1'b1;
        cm_rd[k*5 +: 5]        = rd_q[cidx[k]];
        cm_value[k*XLEN +: XLEN] = val_q[cidx[k]];
        cm_pc[k*XLEN +: XLEN]  = pc_q[cidx[k]];
        cm_npc[k*XLEN +: XLEN] = npc_q[cidx[k]];
        cm_store[k]            = store_q[cidx[k]];
        ncm                    = ncm + TAG_W'(1);
        cm_sseen               = cm_sseen | store_q[cidx[k]];
        if (cm_rdr) begin
          cm_redirect = 1'b1;
          cm_blk      = 1'b1;
        end
        if (serial_q[cidx[k]])
          cm_blk = 1'b1;
      end else begin
        cm_blk = 1'b1;
      end
    end
  end

  // Source lookup against rename status and in-flight results.
  logic [4:0]         rs_a [2];
  logic [1:0]         lk_rdy;
  logic [2*TAG_W-1:0] lk_tag;
  logic [2*XLEN-1:0]  lk_val;
  logic [IDX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]   lk_ptag;

  assign rs_a[0] = rs1;
  assign rs_a[1] = rs2;

  always_comb begin
    lk_rdy  = '0;
    lk_tag  = '0;
    lk_val  = '0;
    lk_idx  = '0;
    lk_ptag = '0;
    for (int s = 0; s < 2; s++) begin
      lk_idx  = rmt_q[rs_a[s]];
      lk_ptag = TAG_W'({1'b0, lk_idx}) + TAG_W'(1);
      if (rs_a[s] != 5'd0 && busy_q[rs_a[s]]) begin
        if (st_q[lk_idx] == ST_WB) begin
          lk_rdy[s]              = 1'b1;
          lk_val[s*XLEN +: XLEN] = val_q[lk_idx];
        end else begin
          lk_tag[s*TAG_W +: TAG_W] = lk_ptag;
`ifdef YSYX_ROB_BYPASS_EN
          for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && wb_tag[p*TAG_W +: TAG_W] == lk_ptag) begin
              lk_rdy[s]                = 1'b1;
              lk_tag[s*TAG_W +: TAG_W] = '0;
              lk_val[s*XLEN +: XLEN]   = wb_value[p*XLEN +: XLEN];
            end
          end
`endif
        end
      end
    end
  end

  assign src1_ready = lk_rdy[0];
  assign src2_ready = lk_rdy[1];
  assign src1_tag   = lk_tag[0 +: TAG_W];
  assign src2_tag   = lk_tag[TAG_W +: TAG_W];
  assign src1_value = lk_val[0 +: XLEN];
  assign src2_value = lk_val[XLEN +: XLEN];

  // Next state: writeback, then commit, then dispatch (dispatch wins on busy).
  logic [TAG_W-1:0] wtag;
  logic [IDX_W-1:0] widx;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    redir_d  = redir_q;
    busy_d   = busy_q;
    rmt_d    = rmt_q;
    st_d     = st_q;
    rd_d     = rd_q;
    pc_d     = pc_q;
    pnpc_d   = pnpc_q;
    val_d    = val_q;
    npc_d    = npc_q;
    store_d  = store_q;
    serial_d = serial_q;
    trap_d   = trap_q;
    wtag     = '0;
    widx     = '0;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      redir_d = 1'b0;
      busy_d  = '0;
      for (int i = 0; i < DEPTH; i++)
        st_d[i] = ST_FREE;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        wtag = wb_tag[p*TAG_W +: TAG_W];
        widx = IDX_W'(wtag - TAG_W'(1));
        if (wb_valid[p] && wtag != '0 && st_q[widx] != ST_FREE) begin
          st_d[widx]   = ST_WB;
          val_d[widx]  = wb_value[p*XLEN +: XLEN];
          npc_d[widx]  = wb_npc[p*XLEN +: XLEN];
          trap_d[widx] = wb_trap[p];
        end
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (cm_valid[k]) begin
          st_d[cidx[k]] = ST_FREE;
          if (rd_q[cidx[k]] != 5'd0
              && rmt_q[rd_q[cidx[k]]] == cidx[k])
            busy_d[rd_q[cidx[k]]] = 1'b0;
        end
      end
      head_d = head_q + ncm[IDX_W-1:0];
      if (cm_redirect)
        redir_d = 1'b1;
      if (fire) begin
        st_d[tail_q]     = ST_EX;
        rd_d[tail_q]     = disp_rd;
        pc_d[tail_q]     = disp_pc;
        pnpc_d[tail_q]   = disp_pnpc;
        store_d[tail_q]  = disp_store;
        serial_d[tail_q] = disp_serial;
        trap_d[tail_q]   = 1'b0;
        tail_d           = tail_q + IDX_W'(1);
        if (disp_rd != 5'd0) begin
          busy_d[disp_rd] = 1'b1;
          rmt_d[disp_rd]  = tail_q;
        end
      end
      count_d = count_q + TAG_W'(fire) - ncm;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      redir_q  <= 1'b0;
      busy_q   <= '0;
      rmt_q    <= '{default: '0};
      st_q     <= '{default: ST_FREE};
      rd_q     <= '{default: '0};
      pc_q     <= '{default: '0};
      pnpc_q   <= '{default: '0};
      val_q    <= '{default: '0};
      npc_q    <= '{default: '0};
      store_q  <= '{default: 1'b0};
      serial_q <= '{default: 1'b0};
      trap_q   <= '{default: 1'b0};
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      redir_q  <= redir_d;
      busy_q   <= busy_d;
      rmt_q    <= rmt_d;
      st_q     <= st_d;
      rd_q     <= rd_d;
      pc_q     <= pc_d;
      pnpc_q   <= pnpc_d;
      val_q    <= val_d;
      npc_q    <= npc_d;
      store_q  <= store_d;
      serial_q <= serial_d;
      trap_q   <= trap_d;
    end
  end

endmodule
